// File: rtl/svi_pattern_gen.sv
// Burst pattern source: CHANNELS lanes of WIDTH-bit data in const/counter/walking-one/LFSR
// modes, delivered beat by beat over a valid/ready handshake.
module svi_pattern_gen #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CHANNELS  = 2,
    parameter int unsigned      LEN_W     = 16,
    parameter logic [WIDTH-1:0] CONST_VAL = '1,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [1:0]                i_mode,
    input  logic [LEN_W-1:0]          i_len,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [CHANNELS*WIDTH-1:0] o_a,
    output logic                      o_last,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned DW = CHANNELS * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [DW-1:0]     a_q,     a_d;
    logic [1:0]        mode_q,  mode_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [LEN_W-1:0]  n_q,     n_d;
    logic [WIDTH-1:0]  lfsr_q,  lfsr_d;

    // Rotate left; sh is always in [0, WIDTH-1] so the right shift by WIDTH yields zero.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int unsigned sh);
        return (x << sh) | (x >> (WIDTH - sh));
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & POLY)};
    endfunction

    // All lanes of one beat, from the beat index and the shared LFSR state.
    function automatic logic [DW-1:0] beat_val(input logic [1:0]       mode,
                                                input logic [LEN_W-1:0] n,
                                                input logic [WIDTH-1:0] l);
        logic [DW-1:0]    v;
        logic [WIDTH-1:0] lane;
        v = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            case (mode)
                2'd0:    lane = CONST_VAL;
                2'd1:    lane = WIDTH'(n) + WIDTH'(c);
                2'd2:    lane = rotl(WIDTH'(1), (32'(n) % WIDTH + c) % WIDTH);
                default: lane = rotl(l, c % WIDTH);
            endcase
            v[c*WIDTH +: WIDTH] = lane;
        end
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        a_d     = a_q;
        mode_d  = mode_q;
        len_d   = len_q;
        n_d     = n_q;
        lfsr_d  = lfsr_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mode_d = i_mode;
                    len_d  = i_len;
                    n_d    = '0;
                    lfsr_d = SEED;
                    if (i_len != '0) begin
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                        a_d     = beat_val(i_mode, '0, SEED);
                        last_d  = (i_len == LEN_W'(1));
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (valid_q && i_ready) begin
                    lfsr_d = lfsr_next(lfsr_q);
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        n_d    = n_q + LEN_W'(1);
                        a_d    = beat_val(mode_q, n_d, lfsr_d);
                        last_d = (n_d == len_q - LEN_W'(1));
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            mode_q  <= '0;
            len_q   <= '0;
            n_q     <= '0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            n_q     <= n_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_a     = a_q;

endmodule

// File: doc/svi_pattern_gen.md
Name: svi_pattern_gen

Overview:
Parametrised successor to the constant-drive struct-over-interface source. It replaces the fixed all-ones 8-bit output with CHANNELS lanes of WIDTH-bit data. Data is generated as a length-bounded burst in one of four selectable pattern modes and delivered over a valid/ready handshake. It sits at the producer end of an interface-carried data bundle and acts as a stimulus/source block for downstream struct consumers.

Parameters:
WIDTH, 8, bits per channel lane (>=2)
CHANNELS, 2, number of lanes packed into o_a (>=1)
LEN_W, 16, width of burst length input
CONST_VAL, all-ones, lane value in constant mode
POLY, 8'hB8, LFSR tap mask (WIDTH bits)
SEED, 1, LFSR start value, must be non-zero

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_start  in  1  burst request, sampled in IDLE only
i_mode  in  2  0 const, 1 counter, 2 walking-one, 3 LFSR; latched at start
i_len  in  LEN_W  beats in burst; latched at start
o_valid  out  1  beat available
i_ready  in  1  consumer accepts beat
o_a  out  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH]
o_last  out  1  current beat is final beat of burst
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse at burst end

Behaviour:
- Reset (i_rst high at edge): state IDLE, o_valid=0, o_last=0, o_busy=0, o_done=0, o_a=0, beat index n=0, LFSR=SEED. Reset mid-burst aborts the burst: no o_done, o_valid low from the next cycle.
- FSM states IDLE, RUN, DONE.
  - IDLE: i_start=1 at edge k latches mode and len and clears n. If len>0, enter RUN; o_valid=1 with beat 0 from cycle k+1. If len==0, enter DONE directly; no beat is issued.
  - RUN: a beat transfers on any edge with o_valid&&i_ready. On transfer of beat n<len-1, n increments and the next beat is presented in the following cycle, so zero-bubble streaming is possible. On transfer with n==len-1, go to DONE; o_valid drops next cycle.
  - DONE: o_done=1 for exactly one cycle, then IDLE. i_start is accepted again from the IDLE cycle onward.
- i_start is ignored in RUN and DONE. i_mode and i_len are don't-care after latching.
- o_busy = (state==RUN). o_last = o_valid && (n==len-1).
- Handshake: while o_valid && !i_ready, o_a and o_last hold stable. o_valid never drops without a transfer, except on reset.
- Lane c value for beat n (all arithmetic mod 2^WIDTH; rotations mod WIDTH):
  - mode 0: CONST_VAL
  - mode 1: n[WIDTH-1:0] + c
  - mode 2: 1 rotated left by (n + c) mod WIDTH
  - mode 3: L rotated left by c, where L is the shared LFSR state. L = SEED at burst start. On each transfer, L <= {L[WIDTH-2:0], ^(L & POLY)}.
- Counter wrap: n counts up to len-1 (LEN_W bits); lane values wrap silently at 2^WIDTH.
- o_a holds its last value while not valid. Consumers qualify o_a with o_valid.

Test Plan:
- Reset then idle, i_ready=1 -> o_valid=0, o_a=0, o_done=0 for 10 cycles; i_start pulse while i_rst=1 has no effect.
- Mode 0, len=3, i_ready=1, defaults -> 3 consecutive beats o_a=16'hFFFF, o_last on beat 3, o_done one cycle after, o_busy low.
- Mode 1, len=4, i_ready toggling 1,0,1,0... -> lanes {ch1,ch0} = {01,00},{02,01},{03,02},{04,03}; values held while i_ready=0. Mode 1, len=300 -> beat 256 shows lane0=00, lane1=01 (wrap).
- Mode 2, len=9 -> lane0 sequence 01,02,04,...,80,01; lane1 = lane0 rotated by 1. Mode 3, len=5 -> lane0 01,02,04,08,11; lane1 02,04,08,10,22.
- len=0 start -> no o_valid, o_done pulses on the cycle after start. i_start held high in RUN -> no restart; exactly len beats delivered.
- Assert i_rst after beat 2 of a len=8 burst -> o_valid=0 next cycle, no o_done; a new start restarts from beat 0 with LFSR=SEED.
